// File: rtl/e203_rvfi_trc_pkg.sv
// Shared types and constants for the RVFI trace buffer: FIFO entry layout,
// beat sequence and the sync byte that opens each serialised packet.
package e203_rvfi_trc_pkg;

  localparam int         ORDER_TAG_W = 14;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;

  typedef enum logic [1:0] {BEAT0, BEAT1, BEAT2, BEAT3} beat_e;

  typedef struct packed {
    logic                   trap;
    logic                   intr;
    logic                   halt;
    logic [1:0]             mode;
    logic [4:0]             rd_addr;
    logic [ORDER_TAG_W-1:0] order;
    logic [31:0]            pc_rdata;
    logic [31:0]            insn;
    logic [31:0]            rd_wdata;
  } trc_entry_t;

endpackage

// File: rtl/e203_rvfi_trc_fifo.sv
// Generic synchronous FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; the caller accounts for rejected pushes.
module e203_rvfi_trc_fifo #(
  parameter int W     = 120,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Extra MSB on each pointer separates full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/e203_rvfi_trace_buf.sv
// RVFI retirement trace buffer: queues retired packets, streams each as four
// 32-bit beats, counts overflow drops and flags order/PC discontinuities.
module e203_rvfi_trace_buf
  import e203_rvfi_trc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trc_en,
  input  logic              rvfi_valid,
  input  logic [63:0]       rvfi_order,
  input  logic [31:0]       rvfi_insn,
  input  logic              rvfi_trap,
  input  logic              rvfi_intr,
  input  logic              rvfi_halt,
  input  logic [1:0]        rvfi_mode,
  input  logic [4:0]        rvfi_rd_addr,
  input  logic [31:0]       rvfi_rd_wdata,
  input  logic [31:0]       rvfi_pc_rdata,
  input  logic [31:0]       rvfi_pc_wdata,
  output logic              trc_valid,
  input  logic              trc_ready,
  output logic [31:0]       trc_data,
  output logic              trc_last,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              err_order,
  output logic              err_pc
);

  trc_entry_t  in_entry, head;
  logic        push, pop, full, empty, hs;
  beat_e       beat_q, beat_d;

  logic [63:0]       prev_order_q, prev_order_d;
  logic [31:0]       prev_pc_q, prev_pc_d;
  logic              prev_flow_q, prev_flow_d;
  logic              have_prev_q, have_prev_d;
  logic              trc_en_q;
  logic              err_order_q, err_order_d;
  logic              err_pc_q, err_pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  assign push = rvfi_valid & trc_en;
  assign hs   = trc_valid & trc_ready;
  assign pop  = hs & (beat_q == BEAT3);

  always_comb begin
    in_entry          = '0;
    in_entry.trap     = rvfi_trap;
    in_entry.intr     = rvfi_intr;
    in_entry.halt     = rvfi_halt;
    in_entry.mode     = rvfi_mode;
    in_entry.rd_addr  = rvfi_rd_addr;
    in_entry.order    = rvfi_order[ORDER_TAG_W-1:0];
    in_entry.pc_rdata = rvfi_pc_rdata;
    in_entry.insn     = rvfi_insn;
    in_entry.rd_wdata = rvfi_rd_wdata;
  end

  e203_rvfi_trc_fifo #(.W($bits(trc_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (in_entry),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // Beat sequencer: state register / next state / output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_q <= BEAT0;
    else        beat_q <= beat_d;
  end

  always_comb begin
    beat_d = beat_q;
    if (hs) beat_d = (beat_q == BEAT3) ? BEAT0 : beat_e'(beat_q + 2'd1);
  end

  always_comb begin
    trc_valid = ~empty;
    trc_data  = '0;
    trc_last  = 1'b0;
    if (!empty) begin
      case (beat_q)
        BEAT0: trc_data = {SYNC_BYTE, head.trap, head.intr, head.halt,
                           head.mode, head.rd_addr, head.order};
        BEAT1: trc_data = head.pc_rdata;
        BEAT2: trc_data = head.insn;
        BEAT3: begin
          trc_data = head.rd_wdata;
          trc_last = 1'b1;
        end
        default: trc_data = '0;
      endcase
    end
  end

  // Checker history follows every push, accepted or dropped.
  always_comb begin
    prev_order_d = prev_order_q;
    prev_pc_d    = prev_pc_q;
    prev_flow_d  = prev_flow_q;
    have_prev_d  = have_prev_q;
    drop_d       = drop_q;
    err_order_d  = push & have_prev_q & (rvfi_order != prev_order_q + 64'd1);
    err_pc_d     = push & have_prev_q & ~prev_flow_q & (rvfi_pc_rdata != prev_pc_q);
    if (push) begin
      prev_order_d = rvfi_order;
      prev_pc_d    = rvfi_pc_wdata;
      prev_flow_d  = rvfi_trap | rvfi_intr;
      have_prev_d  = 1'b1;
    end else if (trc_en_q && !trc_en) begin
      have_prev_d  = 1'b0;
    end
    if (push && full && !pop && drop_q != {DROP_W{1'b1}})
      drop_d = drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_order_q <= '0;
      prev_pc_q    <= '0;
      prev_flow_q  <= 1'b0;
      have_prev_q  <= 1'b0;
      trc_en_q     <= 1'b0;
      err_order_q  <= 1'b0;
      err_pc_q     <= 1'b0;
      drop_q       <= '0;
    end else begin
      prev_order_q <= prev_order_d;
      prev_pc_q    <= prev_pc_d;
      prev_flow_q  <= prev_flow_d;
      have_prev_q  <= have_prev_d;
      trc_en_q     <= trc_en;
      err_order_q  <= err_order_d;
      err_pc_q     <= err_pc_d;
      drop_q       <= drop_d;
    end
  end

  assign drop_cnt  = drop_q;
  assign err_order = err_order_q;
  assign err_pc    = err_pc_q;

endmodule

// File: tb/tb_e203_rvfi_trace_buf.sv
// Directed bench for e203_rvfi_trace_buf: single packet, backpressure,
// overflow, order/PC checks and reset mid-packet.
module tb_e203_rvfi_trace_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trc_en;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap, rvfi_intr, rvfi_halt;
  logic [1:0]  rvfi_mode;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata;
  logic        trc_valid, trc_ready, trc_last;
  logic [31:0] trc_data;
  logic [15:0] drop_cnt;
  logic        err_order, err_pc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  e203_rvfi_trace_buf #(.DEPTH(4), .DROP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .trc_en(trc_en), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
    .rvfi_intr(rvfi_intr), .rvfi_halt(rvfi_halt), .rvfi_mode(rvfi_mode),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_data(trc_data),
    .trc_last(trc_last), .drop_cnt(drop_cnt), .err_order(err_order), .err_pc(err_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] ord, input logic [31:0] pcr, input logic [31:0] pcw,
                       input logic [31:0] insn, input logic [4:0] rd, input logic [31:0] wd,
                       input logic trap);
    rvfi_valid    = 1'b1;
    rvfi_order    = ord;
    rvfi_pc_rdata = pcr;
    rvfi_pc_wdata = pcw;
    rvfi_insn     = insn;
    rvfi_rd_addr  = rd;
    rvfi_rd_wdata = wd;
    rvfi_trap     = trap;
  endtask

  logic [31:0] bp_data [8];
  logic        bp_last [8];

  initial begin
    rst_n = 1'b0; trc_en = 1'b0; rvfi_valid = 1'b0; rvfi_order = '0; rvfi_insn = '0;
    rvfi_trap = 1'b0; rvfi_intr = 1'b0; rvfi_halt = 1'b0; rvfi_mode = '0;
    rvfi_rd_addr = '0; rvfi_rd_wdata = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    trc_ready = 1'b0;
    #1;
    chk("rst_valid", trc_valid, 0);
    chk("rst_data", trc_data, 0);
    chk("rst_last", trc_last, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_errs", {err_order, err_pc}, 0);
    step(); step();
    rst_n = 1'b1; trc_en = 1'b1;
    step();

    // Single packet
    trc_ready = 1'b1;
    drive(64'd5, 32'h8000_0000, 32'h8000_0004, 32'h0010_0093, 5'd1, 32'h1, 1'b0);
    step(); rvfi_valid = 1'b0;
    chk("p1_valid", trc_valid, 1);
    chk("p1_beat0", trc_data, 32'hA500_4005);
    chk("p1_last0", trc_last, 0);
    chk("p1_first_err", {err_order, err_pc}, 0);
    step(); chk("p1_beat1", trc_data, 32'h8000_0000);
    step(); chk("p1_beat2", trc_data, 32'h0010_0093);
    chk("p1_last2", trc_last, 0);
    step(); chk("p1_beat3", trc_data, 32'h0000_0001);
    chk("p1_last3", trc_last, 1);
    step(); chk("p1_empty_valid", trc_valid, 0);
    chk("p1_empty_data", trc_data, 0);

    // Backpressure: ready alternates 0/1, each beat held while not ready
    trc_ready = 1'b0;
    drive(64'd6, 32'h8000_0004, 32'h8000_0008, 32'h1234_5678, 5'd2, 32'hDEAD_BEEF, 1'b0);
    step(); rvfi_valid = 1'b0;
    chk("bp_beat0", trc_data, 32'hA500_8006);
    chk("bp_errs", {err_order, err_pc}, 0);
    bp_data = '{32'hA500_8006, 32'h8000_0004, 32'h8000_0004, 32'h1234_5678,
                32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    bp_last = '{0, 0, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      trc_ready = (i % 2 == 1);
      step();
      chk($sformatf("bp_data%0d", i), trc_data, bp_data[i]);
      chk($sformatf("bp_last%0d", i), trc_last, bp_last[i]);
    end
    chk("bp_done", trc_valid, 0);

    // Overflow: six retirements with the sink stalled
    trc_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(64'(i), 32'h1000 + 32'(4*i), 32'h1004 + 32'(4*i), 32'h13, 5'd0, 32'(i), 1'b0);
      step();
    end
    rvfi_valid = 1'b0;
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_head", trc_data, 32'hA500_0000);
    trc_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("ovf_pkt%0d_b0", p), trc_data, 32'hA500_0000 | 32'(p));
      step(); step(); step();
      chk($sformatf("ovf_pkt%0d_b3", p), trc_data, 32'(p));
      step();
    end
    chk("ovf_drained", trc_valid, 0);
    chk("ovf_drop_hold", drop_cnt, 2);

    // Order check after re-enable: 10, 11, 13
    trc_en = 1'b0; step();
    trc_en = 1'b1; step();
    drive(64'd10, 32'h200, 32'h204, 32'h13, 5'd0, 0, 1'b0); step();
    chk("ord10", {err_order, err_pc}, 0);
    drive(64'd11, 32'h204, 32'h208, 32'h13, 5'd0, 0, 1'b0); step();
    chk("ord11", {err_order, err_pc}, 0);
    drive(64'd13, 32'h208, 32'h20C, 32'h13, 5'd0, 0, 1'b0); step();
    chk("ord13_err", err_order, 1);
    chk("ord13_pc", err_pc, 0);
    rvfi_valid = 1'b0; step();
    chk("ord_pulse_end", err_order, 0);
    for (int i = 0; i < 12; i++) step();

    // PC check, then the same jump after a trapping packet
    drive(64'd14, 32'h20C, 32'h100, 32'h13, 5'd0, 0, 1'b0); step();
    chk("pc_a", {err_order, err_pc}, 0);
    drive(64'd15, 32'h104, 32'h108, 32'h13, 5'd0, 0, 1'b0); step();
    chk("pc_b_err", err_pc, 1);
    chk("pc_b_ord", err_order, 0);
    drive(64'd16, 32'h108, 32'h100, 32'h13, 5'd0, 0, 1'b1); step();
    chk("pc_trap_a", err_pc, 0);
    drive(64'd17, 32'h104, 32'h108, 32'h13, 5'd0, 0, 1'b0); step();
    chk("pc_trap_b", err_pc, 0);
    rvfi_valid = 1'b0; step();
    chk("pc_quiet", {err_order, err_pc}, 0);
    for (int i = 0; i < 20; i++) step();
    chk("pc_drained", trc_valid, 0);

    // Reset during BEAT2
    drive(64'd18, 32'h108, 32'h10C, 32'hCAFE_0013, 5'd3, 32'h55, 1'b0); step();
    rvfi_valid = 1'b0;
    step(); step();
    chk("rm_beat2", trc_data, 32'hCAFE_0013);
    rst_n = 1'b0; #1;
    chk("rm_valid", trc_valid, 0);
    chk("rm_drop", drop_cnt, 0);
    chk("rm_data", trc_data, 0);
    step();
    rst_n = 1'b1;
    step();
    drive(64'd100, 32'h400, 32'h404, 32'h0000_0073, 5'd4, 32'h77, 1'b0); step();
    rvfi_valid = 1'b0;
    chk("rm_first_err", {err_order, err_pc}, 0);
    chk("rm_beat0", trc_data, 32'hA501_0064);
    step();
    chk("rm_beat1", trc_data, 32'h0000_0400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
